// File: rtl/futaba_rx.sv
// futaba_rx: Futaba VFD link receiver (TCLK/SI/TLAT/TBK).
// Oversamples the link on C, deserialises 96-bit frames, decodes the one-hot
// grid field to an index, and measures TBK (blanking) pulse length.
// Optional build macro: FUTABA_RX_SYNC_EN adds a two-flop synchroniser on every
// link pin for use when the link comes from another clock domain.
module futaba_rx #(
  parameter int FRAME_BITS = 96,
  parameter int GRIDS      = 20
) (
  input  logic        C,
  input  logic        aR,
  input  logic        TCLK,
  input  logic        SI,
  input  logic        TLAT,
  input  logic        TBK,
  output logic [80:0] Data,
  output logic        Valid,
  output logic        GridErr,
  output logic        LenErr,
  output logic        Blank,
  output logic [6:0]  BkLen
);

  // Pin bundle order: {TBK, TLAT, SI, TCLK}. TCLK idles high, so its flops
  // reset to 1 to avoid a false shift edge on reset release.
  localparam logic [3:0] PIN_RST = 4'b0001;

  logic [3:0] pin, s_in, s, p;
  assign pin = {TBK, TLAT, SI, TCLK};

`ifdef FUTABA_RX_SYNC_EN
  logic [3:0] sync1, sync2;

  // Two-flop synchroniser on all link wires.
  always_ff @(posedge C or posedge aR) begin
    if (aR) begin
      sync1 <= PIN_RST;
      sync2 <= PIN_RST;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end
  assign s_in = sync2;
`else
  assign s_in = pin;
`endif

  // Sample stage s and previous stage p for edge detection.
  always_ff @(posedge C or posedge aR) begin
    if (aR) begin
      s <= PIN_RST;
      p <= PIN_RST;
    end else begin
      s <= s_in;
      p <= s;
    end
  end

  logic tclk_rise, tlat_rise, tbk_rise, tbk_fall, s_si, s_tbk;
  assign s_si      = s[1];
  assign s_tbk     = s[3];
  assign tclk_rise = s[0] & ~p[0];
  assign tlat_rise = s[2] & ~p[2];
  assign tbk_rise  = s[3] & ~p[3];
  assign tbk_fall  = ~s[3] & p[3];
  assign Blank     = s_tbk;

  logic [FRAME_BITS-1:0] sr, sr_n;
  logic [6:0]            bit_cnt, bit_cnt_n;
  logic [GRIDS-1:0]      g;
  logic [4:0]            grid_idx, grid_ones;

  // Next-state shift register and count; a latch in the same cycle as a
  // shift sees the post-shift values, so the 96th bit is never lost.
  always_comb begin
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    if (tclk_rise) begin
      sr_n      = {sr[FRAME_BITS-2:0], s_si};
      bit_cnt_n = (bit_cnt == 7'd127) ? bit_cnt : bit_cnt + 7'd1;
    end
  end

  // Grid decode: g[0] is the first bit sent (SR MSB). Lowest set bit wins,
  // so iterate downward and let later (lower) hits overwrite.
  always_comb begin
    g         = '0;
    grid_idx  = '0;
    grid_ones = '0;
    for (int i = GRIDS - 1; i >= 0; i--) begin
      g[i]      = sr_n[FRAME_BITS-1-i];
      grid_ones = grid_ones + 5'(g[i]);
      if (g[i]) grid_idx = 5'(i);
    end
  end

  // Frame shift, latch acceptance and output registers.
  always_ff @(posedge C or posedge aR) begin
    if (aR) begin
      sr      <= '0;
      bit_cnt <= '0;
      Data    <= '0;
      Valid   <= 1'b0;
      GridErr <= 1'b0;
      LenErr  <= 1'b0;
    end else begin
      sr    <= sr_n;
      Valid <= 1'b0;
      if (tlat_rise) begin
        bit_cnt <= '0;
        if (bit_cnt_n == 7'(FRAME_BITS)) begin
          Data    <= {grid_idx, sr_n[75:0]};
          GridErr <= (grid_ones != 5'd1);
          LenErr  <= 1'b0;
          Valid   <= 1'b1;
        end else begin
          LenErr <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt_n;
      end
    end
  end

  logic [6:0] bk_cnt;

  // Blanking pulse length: the rise cycle counts as the first high cycle,
  // so BkLen equals the number of cycles s.TBK was high.
  always_ff @(posedge C or posedge aR) begin
    if (aR) begin
      bk_cnt <= '0;
      BkLen  <= '0;
    end else begin
      if (tbk_rise)
        bk_cnt <= 7'd1;
      else if (s_tbk && bk_cnt != 7'd127)
        bk_cnt <= bk_cnt + 7'd1;
      if (tbk_fall)
        BkLen <= bk_cnt;
    end
  end

endmodule

// File: tb/tb_futaba_rx.sv
// Bench for futaba_rx: table-driven frames plus hand sequences for latency,
// simultaneous TCLK/TLAT edges, blanking length and mid-frame reset.
module tb_futaba_rx;

  logic        C = 1'b0;
  logic        aR, TCLK, SI, TLAT, TBK;
  logic [80:0] Data;
  logic        Valid, GridErr, LenErr, Blank;
  logic [6:0]  BkLen;

`ifdef FUTABA_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  futaba_rx dut (
    .C(C), .aR(aR), .TCLK(TCLK), .SI(SI), .TLAT(TLAT), .TBK(TBK),
    .Data(Data), .Valid(Valid), .GridErr(GridErr), .LenErr(LenErr),
    .Blank(Blank), .BkLen(BkLen)
  );

  always #5 C = ~C;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;

  always @(negedge C) if (Valid === 1'b1) vcnt++;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Frame word as transmitted: {grid field, segments}; g[i] sits at bit 95-i.
  function automatic logic [95:0] mk(input logic [19:0] gm, input logic [75:0] seg);
    logic [19:0] gf;
    for (int i = 0; i < 20; i++) gf[19-i] = gm[i];
    return {gf, seg};
  endfunction

  // mode 0: no latch, 1: separate latch pulse, 2: TLAT rises with last TCLK.
  task automatic send(input logic [95:0] fw, input int n, input int mode);
    for (int b = 0; b < n; b++) begin
      @(negedge C);
      TCLK = 1'b0;
      SI   = (b < 96) ? fw[95-b] : 1'b0;
      repeat (2) @(negedge C);
      TCLK = 1'b1;
      if (mode == 2 && b == n - 1) TLAT = 1'b1;
      @(negedge C);
    end
    if (mode == 1) begin
      @(negedge C);
      TLAT = 1'b1;
      repeat (2) @(negedge C);
    end
    if (mode != 0) begin
      @(negedge C);
      TLAT = 1'b0;
      repeat (6) @(negedge C);
    end
  endtask

  typedef struct {
    logic [19:0] gm;
    logic [75:0] seg;
    int          nbits;
    int          exp_v;
    logic [4:0]  exp_idx;
    logic [75:0] exp_seg;
    logic        exp_gerr;
    logic        exp_lerr;
  } vec_t;

  vec_t tv[8];

  localparam logic [75:0] SA = 76'hDEAD_BEEF_0123_4567_89A;
  localparam logic [75:0] SB = 76'h123_4567_89AB_CDEF_0123;
  localparam logic [75:0] SC = 76'hFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [75:0] SD = 76'h555_5555_5555_5555_5555;
  localparam logic [75:0] SE = 76'hABC_0000_1111_2222_3333;
  localparam logic [75:0] SF = 76'h0F0_F0F0_1234_5678_9ABD;

  initial begin
    int v0;
    logic [95:0] fw;

    tv[0] = '{20'h00020, SA, 96, 1, 5'd5,  SA, 1'b0, 1'b0};
    tv[1] = '{20'h00088, SB, 96, 1, 5'd3,  SB, 1'b1, 1'b0};
    tv[2] = '{20'h00000, SC, 96, 1, 5'd0,  SC, 1'b1, 1'b0};
    tv[3] = '{20'h00001, SD, 95, 0, 5'd0,  SC, 1'b1, 1'b1};
    tv[4] = '{20'h80000, SD, 96, 1, 5'd19, SD, 1'b0, 1'b0};
    tv[5] = '{20'h00001, SE, 97, 0, 5'd19, SD, 1'b0, 1'b1};
    tv[6] = '{20'h00001, SE, 96, 1, 5'd0,  SE, 1'b0, 1'b0};
    tv[7] = '{20'hFFFFF, SA, 96, 1, 5'd0,  SA, 1'b1, 1'b0};

    aR = 1'b1; TCLK = 1'b1; SI = 1'b0; TLAT = 1'b0; TBK = 1'b0;
    repeat (3) @(negedge C);
    chk("rst_data",    96'(Data),    96'd0);
    chk("rst_valid",   96'(Valid),   96'd0);
    chk("rst_griderr", 96'(GridErr), 96'd0);
    chk("rst_lenerr",  96'(LenErr),  96'd0);
    chk("rst_blank",   96'(Blank),   96'd0);
    chk("rst_bklen",   96'(BkLen),   96'd0);
    aR = 1'b0;
    repeat (4) @(negedge C);

    for (int i = 0; i < 8; i++) begin
      v0 = vcnt;
      send(mk(tv[i].gm, tv[i].seg), tv[i].nbits, 1);
      chk($sformatf("v%0d_valid", i),   96'(vcnt - v0),  96'(tv[i].exp_v));
      chk($sformatf("v%0d_data", i),    96'(Data),       96'({tv[i].exp_idx, tv[i].exp_seg}));
      chk($sformatf("v%0d_griderr", i), 96'(GridErr),    96'(tv[i].exp_gerr));
      chk($sformatf("v%0d_lenerr", i),  96'(LenErr),     96'(tv[i].exp_lerr));
    end

    // Latency: Valid exactly on negedge LAT+1 after TLAT is driven high.
    send(mk(20'h00020, SA), 96, 0);
    @(negedge C);
    TLAT = 1'b1;
    repeat (LAT) @(negedge C);
    chk("lat_early", 96'(Valid), 96'd0);
    @(negedge C);
    chk("lat_on",    96'(Valid), 96'd1);
    TLAT = 1'b0;
    @(negedge C);
    chk("lat_after", 96'(Valid), 96'd0);
    repeat (6) @(negedge C);

    // Simultaneous 96th TCLK rise and TLAT rise.
    v0 = vcnt;
    send(mk(20'h00400, SF), 96, 2);
    chk("sim_valid",  96'(vcnt - v0), 96'd1);
    chk("sim_data",   96'(Data),      96'({5'd10, SF}));
    chk("sim_lenerr", 96'(LenErr),    96'd0);

    // Blanking pulses.
    TBK = 1'b1;
    repeat (20) @(negedge C);
    chk("bk_blank_hi", 96'(Blank), 96'd1);
    repeat (20) @(negedge C);
    TBK = 1'b0;
    repeat (6) @(negedge C);
    chk("bk_len40",    96'(BkLen), 96'd40);
    chk("bk_blank_lo", 96'(Blank), 96'd0);
    TBK = 1'b1;
    repeat (200) @(negedge C);
    TBK = 1'b0;
    repeat (6) @(negedge C);
    chk("bk_len_sat",  96'(BkLen), 96'd127);

    // Reset mid-frame, then a clean frame.
    fw = mk(20'h00100, SB);
    send(fw, 50, 0);
    @(negedge C);
    aR = 1'b1;
    @(negedge C);
    chk("mr_data",    96'(Data),    96'd0);
    chk("mr_valid",   96'(Valid),   96'd0);
    chk("mr_griderr", 96'(GridErr), 96'd0);
    chk("mr_bklen",   96'(BkLen),   96'd0);
    @(negedge C);
    aR = 1'b0;
    repeat (4) @(negedge C);
    v0 = vcnt;
    send(fw, 96, 1);
    chk("mr2_valid",  96'(vcnt - v0), 96'd1);
    chk("mr2_data",   96'(Data),      96'({5'd8, SB}));
    chk("mr2_lenerr", 96'(LenErr),    96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
